sub2x16_approx_pipe: RTL

Two-stage pipelined approximate 16-bit subtractor. It is the inverse-direction companion of the approximate 16-bit adders in the approximate-arithmetic library: it computes O ≈ A − B with the low APPROX_LSBS bits approximated and a predicted borrow. It accepts operands on a valid/ready input interface and returns results on a valid/ready output interface. It sits in datapaths that need difference, error or residual terms beside the approximate adders.

---
 rtl/sub2x16_approx_pipe.sv | 116 +++++++++++
 1 files changed

// File: rtl/sub2x16_approx_pipe.sv
// Two-stage pipelined approximate subtractor: low K bits pass A through, borrow predicted from bit K-1.
// Optional error statistics (err_cnt, err_max, stats_clr) when SUB_ERR_STATS_EN is defined.
module sub2x16_approx_pipe #(
  parameter int WIDTH       = 16,
  parameter int APPROX_LSBS = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_diff,
  output logic             out_borrow
`ifdef SUB_ERR_STATS_EN
  ,
  input  logic             stats_clr,
  output logic [15:0]      err_cnt,
  output logic [WIDTH-1:0] err_max
`endif
);

  localparam int K  = APPROX_LSBS;
  localparam int HW = WIDTH - K;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [HW-1:0]    s1_b_hi;
  logic             s1_bp;
  logic             s1_ready;
  logic             s2_ready;
  logic             in_xfer;
  logic             s1_adv;
  logic [HW:0]      hi_ext;

  assign s2_ready = ~out_valid | out_ready;
  assign s1_ready = ~s1_valid | s2_ready;
  assign in_ready = s1_ready;
  assign in_xfer  = in_valid & s1_ready;
  assign s1_adv   = s1_valid & s2_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else if (s1_ready) begin
      s1_valid <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (in_xfer) begin
      s1_a    <= in_a;
      s1_b_hi <= in_b[WIDTH-1:K];
      s1_bp   <= ~in_a[K-1] & in_b[K-1];
    end
  end

  // Upper field subtract with an extra bit to expose the borrow out
  assign hi_ext = {1'b0, s1_a[WIDTH-1:K]}
                - {1'b0, s1_b_hi}
                - {{HW{1'b0}}, s1_bp};

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_diff   <= '0;
      out_borrow <= 1'b0;
    end else begin
      if (s2_ready) begin
        out_valid <= s1_valid;
      end
      if (s1_adv) begin
        out_diff   <= {hi_ext[HW-1:0], s1_a[K-1:0]};
        out_borrow <= hi_ext[HW];
      end
    end
  end

`ifdef SUB_ERR_STATS_EN
  logic [WIDTH-1:0] s1_exact;
  logic [WIDTH-1:0] s2_exact;
  logic [WIDTH:0]   err_s;
  logic [WIDTH:0]   err_abs;
  logic             out_xfer;

  assign out_xfer = out_valid & out_ready;
  assign err_s    = {1'b0, out_diff} - {1'b0, s2_exact};
  assign err_abs  = err_s[WIDTH] ? (~err_s + 1'b1) : err_s;

  always_ff @(posedge clk) begin
    if (in_xfer) begin
      s1_exact <= in_a - in_b;
    end
    if (s1_adv) begin
      s2_exact <= s1_exact;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || stats_clr) begin
      err_cnt <= '0;
      err_max <= '0;
    end else if (out_xfer && (out_diff != s2_exact)) begin
      if (err_cnt != 16'hFFFF) begin
        err_cnt <= err_cnt + 16'd1;
      end
      if (err_abs[WIDTH-1:0] > err_max) begin
        err_max <= err_abs[WIDTH-1:0];
      end
    end
  end
`endif

endmodule
